// File: rtl/mem_sync_pkg.sv
// rtl/mem_sync_pkg.sv - shared types and helpers for the host-memory sync responder
package mem_sync_pkg;

   // Responder FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } sync_state_t;

   // Sync request direction as seen on sync_wb
   typedef enum logic {
      SYNC_FILL = 1'b0,
      SYNC_WB   = 1'b1
   } sync_type_t;

   // Flat bank index {bg,ba} used for arbitration and the host command
   function automatic int flat_bank_idx(input int bg, input int ba, input int banks_per_group);
      return bg * banks_per_group + ba;
   endfunction

endpackage

// File: rtl/mem_sync_rr_arb.sv
// rtl/mem_sync_rr_arb.sv - N-way round-robin arbiter with one-cycle mask
module mem_sync_rr_arb #(
   parameter int N  = 16,
   parameter int IW = 4
) (
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          valid
);

   logic [N-1:0]  eligible;
   logic [IW-1:0] cand;

   assign eligible = req & ~mask;

   // Scan from ptr upward; N is a power of two so IW-bit addition wraps for free
   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int off = 0; off < N; off++) begin
         cand = ptr + IW'(off);
         if (!valid && eligible[cand]) begin
            valid       = 1'b1;
            idx         = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_sync_responder.sv
// rtl/mem_sync_responder.sv - arbitrates bank row-cache sync requests onto the host port; optional watchdog under SYNC_TIMEOUT_EN
module mem_sync_responder
   import mem_sync_pkg::*;
#(
   parameter int BGWIDTH      = 2,
   parameter int BAWIDTH      = 2,
   parameter int CHWIDTH      = 5,
   parameter int ADDRWIDTH    = 17,
   parameter int BEATS        = 8,
   parameter int SYNC_TIMEOUT = 1024
) (
   input  logic                                                    clk,
   input  logic                                                    rst,
   input  logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0]                   sync_req,
   input  logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0]                   sync_wb,
   input  logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][ADDRWIDTH-1:0]    RowId,
   input  logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][CHWIDTH-1:0]      cRowId,
   output logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0]                   sync_done,
   output logic                                                    host_cmd_valid,
   input  logic                                                    host_cmd_ready,
   output logic                                                    host_cmd_wr,
   output logic [ADDRWIDTH-1:0]                                    host_cmd_row,
   output logic [CHWIDTH-1:0]                                      host_cmd_crow,
   output logic [BGWIDTH+BAWIDTH-1:0]                              host_cmd_bank,
   input  logic                                                    host_beat,
   output logic                                                    busy,
   output logic                                                    sync_err
);

   localparam int BANKGROUPS    = 2**BGWIDTH;
   localparam int BANKSPERGROUP = 2**BAWIDTH;
   localparam int N             = BANKGROUPS * BANKSPERGROUP;
   localparam int IW            = BGWIDTH + BAWIDTH;
   localparam int CW            = $clog2(BEATS) + 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   sync_state_t          state, next_state;
   logic [N-1:0]         req_flat, arb_grant, grant_q, mask, done_flat;
   logic [IW-1:0]        arb_idx, rr_ptr;
   logic [BGWIDTH-1:0]   arb_bg;
   logic [BAWIDTH-1:0]   arb_ba;
   logic                 arb_valid;
   logic [CW-1:0]        beat_cnt;
   logic                 wd_expire;

   assign arb_bg = arb_idx[IW-1:BAWIDTH];
   assign arb_ba = arb_idx[BAWIDTH-1:0];

   // Flatten the per-bank request matrix into the arbiter's index space
   always_comb begin
      req_flat = '0;
      for (int g = 0; g < BANKGROUPS; g++)
         for (int b = 0; b < BANKSPERGROUP; b++)
            req_flat[flat_bank_idx(g, b, BANKSPERGROUP)] = sync_req[g][b];
   end

   mem_sync_rr_arb #(.N(N), .IW(IW)) u_arb (
      .req   (req_flat),
      .mask  (mask),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   // State register; reset aborts any transfer without a completion pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic: one command, BEATS beats, one completion cycle
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (arb_valid) next_state = CMD;
         CMD: begin
            if (host_cmd_ready) next_state = DATA;
            else if (wd_expire) next_state = DONE;
         end
         DATA: begin
            if (host_beat && beat_cnt == LAST_BEAT) next_state = DONE;
            else if (wd_expire)                     next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Grant capture, beat counting, pointer advance and one-cycle re-serve mask
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_q       <= '0;
         host_cmd_bank <= '0;
         host_cmd_wr   <= 1'b0;
         host_cmd_row  <= '0;
         host_cmd_crow <= '0;
         beat_cnt      <= '0;
         rr_ptr        <= '0;
         mask          <= '0;
      end else begin
         mask <= '0;
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  grant_q       <= arb_grant;
                  host_cmd_bank <= arb_idx;
                  host_cmd_wr   <= (sync_type_t'(sync_wb[arb_bg][arb_ba]) == SYNC_WB);
                  host_cmd_row  <= RowId[arb_bg][arb_ba];
                  host_cmd_crow <= cRowId[arb_bg][arb_ba];
               end
            end
            CMD: if (host_cmd_ready) beat_cnt <= '0;
            DATA: if (host_beat && beat_cnt != LAST_BEAT) beat_cnt <= beat_cnt + CW'(1);
            DONE: begin
               rr_ptr <= host_cmd_bank + IW'(1);
               mask   <= grant_q;
            end
            default: ;
         endcase
      end
   end

`ifdef SYNC_TIMEOUT_EN
   localparam int WDW = $clog2(SYNC_TIMEOUT + 1);
   logic [WDW-1:0] wd_cnt;
   logic           stalled;

   assign stalled   = (state == CMD && !host_cmd_ready) || (state == DATA && !host_beat);
   assign wd_expire = stalled && (wd_cnt == WDW'(SYNC_TIMEOUT - 1));

   // Watchdog: counts stalled cycles, any progress restarts it; error is sticky
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt   <= '0;
         sync_err <= 1'b0;
      end else begin
         if (stalled) wd_cnt <= wd_cnt + WDW'(1);
         else         wd_cnt <= '0;
         if (wd_expire) sync_err <= 1'b1;
      end
   end
`else
   assign wd_expire = 1'b0;
   assign sync_err  = 1'b0;
`endif

   assign host_cmd_valid = (state == CMD);
   assign busy           = (state != IDLE);
   assign done_flat      = (state == DONE) ? grant_q : '0;

   // Route the completion pulse back to the served bank
   always_comb begin
      sync_done = '0;
      for (int g = 0; g < BANKGROUPS; g++)
         for (int b = 0; b < BANKSPERGROUP; b++)
            sync_done[g][b] = done_flat[flat_bank_idx(g, b, BANKSPERGROUP)];
   end

endmodule

// File: tb/tb_mem_sync_responder.sv
// tb/tb_mem_sync_responder.sv - self-checking bench for mem_sync_responder
module tb_mem_sync_responder;

   localparam int BEATS = 8;
   localparam int NB    = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [15:0]       req_flat, wb_flat;
   logic [15:0][16:0] row_arr;
   logic [15:0][4:0]  crow_arr;
   logic [3:0][3:0]   sync_done;
   logic [15:0]       done_flat;
   logic              host_cmd_valid, host_cmd_ready, host_cmd_wr, host_beat, busy, sync_err;
   logic [16:0]       host_cmd_row;
   logic [4:0]        host_cmd_crow;
   logic [3:0]        host_cmd_bank;

   int n_cmp = 0;
   int n_err = 0;
   int ptr_m = 0;

   assign done_flat = sync_done;

   always #5 clk = ~clk;

   mem_sync_responder #(
      .BGWIDTH(2), .BAWIDTH(2), .CHWIDTH(5), .ADDRWIDTH(17), .BEATS(BEATS), .SYNC_TIMEOUT(16)
   ) dut (
      .clk(clk), .rst(rst),
      .sync_req(req_flat), .sync_wb(wb_flat), .RowId(row_arr), .cRowId(crow_arr),
      .sync_done(sync_done),
      .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
      .host_cmd_wr(host_cmd_wr), .host_cmd_row(host_cmd_row), .host_cmd_crow(host_cmd_crow),
      .host_cmd_bank(host_cmd_bank), .host_beat(host_beat),
      .busy(busy), .sync_err(sync_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      host_cmd_ready = 1'b0;
      host_beat = 1'b0;
      req_flat = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      ptr_m = 0;
   endtask

   // Reference: first requester at or after ptr (wrapping), skipping the just-served bank
   function automatic int first_req(input logic [15:0] r, input int ptr, input int excl);
      for (int k = 0; k < NB; k++) begin
         int i;
         i = (ptr + k) % NB;
         if (r[i] && i != excl) return i;
      end
      return -1;
   endfunction

   function automatic int onehot_idx(input logic [15:0] v);
      if ($countones(v) != 1) return -1;
      for (int i = 0; i < NB; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic void randomize_fields();
      for (int i = 0; i < NB; i++) begin
         row_arr[i]  = 17'($urandom);
         crow_arr[i] = 5'($urandom);
         wb_flat[i]  = 1'($urandom);
      end
   endfunction

   // Host-side driver: waits for a command, applies backpressure and gapped beats, observes completion
   task automatic run_transfer(input int rdy_delay, input int gap_max, input bit drop_req,
                               output int bank, output logic wr_o, output logic [16:0] row_o,
                               output logic [4:0] crow_o, output bit stable, output bit early,
                               output int done_bank, output bit done_again, output int wait_ticks);
      int gap;
      bank = -1; wr_o = 1'b0; row_o = '0; crow_o = '0;
      stable = 1'b1; early = 1'b0; done_bank = -1; done_again = 1'b0; wait_ticks = 0;
      while (host_cmd_valid !== 1'b1 && wait_ticks < 200) begin
         tick();
         wait_ticks++;
      end
      if (host_cmd_valid !== 1'b1) return;
      bank   = int'(host_cmd_bank);
      wr_o   = host_cmd_wr;
      row_o  = host_cmd_row;
      crow_o = host_cmd_crow;
      if (drop_req) begin
         req_flat[bank] = 1'b0;
         row_arr[bank]  = ~row_arr[bank];
         crow_arr[bank] = ~crow_arr[bank];
         wb_flat[bank]  = ~wb_flat[bank];
      end
      for (int d = 0; d <= rdy_delay; d++) begin
         if (d > 0) tick();
         if (done_flat !== '0) early = 1'b1;
         if (host_cmd_valid !== 1'b1 || int'(host_cmd_bank) != bank || host_cmd_wr !== wr_o ||
             host_cmd_row !== row_o || host_cmd_crow !== crow_o) stable = 1'b0;
      end
      host_cmd_ready = 1'b1;
      host_beat = 1'b0;
      tick();
      host_cmd_ready = 1'b0;
      for (int b = 0; b < BEATS; b++) begin
         gap = $urandom_range(gap_max, 0);
         for (int g = 0; g < gap; g++) begin
            if (done_flat !== '0) early = 1'b1;
            tick();
         end
         if (done_flat !== '0) early = 1'b1;
         host_beat = 1'b1;
         tick();
         host_beat = 1'b0;
      end
      done_bank = onehot_idx(done_flat);
      tick();
      done_again = (done_flat !== '0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_cmp++; if (done_flat !== '0)        begin n_err++; $display("FAIL reset_done: got %h want 0", done_flat); end
      n_cmp++; if (host_cmd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", host_cmd_valid); end
      n_cmp++; if ({host_cmd_wr, host_cmd_row, host_cmd_crow, host_cmd_bank} !== '0)
                  begin n_err++; $display("FAIL reset_fields: got %b/%h/%h/%h want 0", host_cmd_wr, host_cmd_row, host_cmd_crow, host_cmd_bank); end
      n_cmp++; if (busy !== 1'b0)           begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (sync_err !== 1'b0)       begin n_err++; $display("FAIL reset_err: got %b want 0", sync_err); end
      rst = 1'b0;
      tick();
      n_cmp++; if (busy !== 1'b0)           begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_single_fill();
      int pulses, done_cyc;
      bit bad_bit;
      do_reset();
      pulses = 0; done_cyc = -1; bad_bit = 1'b0;
      randomize_fields();
      row_arr[6] = 17'h1ABCD; crow_arr[6] = 5'd7; wb_flat[6] = 1'b0;
      req_flat[6] = 1'b1;
      host_cmd_ready = 1'b1;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         tick();
         if (cyc == 2)  host_beat = 1'b1;
         if (cyc == 10) host_beat = 1'b0;
         if (cyc == 1) begin
            n_cmp++; if (host_cmd_valid !== 1'b1) begin n_err++; $display("FAIL fill_valid: got %b want 1", host_cmd_valid); end
            n_cmp++; if (host_cmd_bank !== 4'd6)  begin n_err++; $display("FAIL fill_bank: got %0d want 6", host_cmd_bank); end
            n_cmp++; if (host_cmd_row !== 17'h1ABCD) begin n_err++; $display("FAIL fill_row: got %h want 1abcd", host_cmd_row); end
            n_cmp++; if (host_cmd_crow !== 5'd7 || host_cmd_wr !== 1'b0)
                        begin n_err++; $display("FAIL fill_crow_wr: got %0d/%b want 7/0", host_cmd_crow, host_cmd_wr); end
         end
         if (done_flat !== '0) begin
            pulses++;
            done_cyc = cyc;
            if (done_flat !== 16'h0040) bad_bit = 1'b1;
         end
         if (cyc == 11) req_flat[6] = 1'b0;
      end
      host_cmd_ready = 1'b0;
      n_cmp++; if (done_cyc != 10 || pulses != 1 || bad_bit)
                  begin n_err++; $display("FAIL fill_done: got cycle %0d pulses %0d badbit %0d want cycle 10 pulses 1", done_cyc, pulses, bad_bit); end
      ptr_m = 7;
   endtask

   task automatic test_round_robin();
      int exp, bank, done_bank, wt, last, prev;
      logic wr; logic [16:0] row; logic [4:0] crow;
      bit stable, early, again;
      do_reset();
      randomize_fields();
      req_flat = '0;
      req_flat[0] = 1'b1; req_flat[5] = 1'b1; req_flat[15] = 1'b1;
      last = -1; prev = -1;
      for (int k = 0; k < 4; k++) begin
         exp = first_req(req_flat, ptr_m, last);
         run_transfer($urandom_range(2, 0), 1, 1'b0, bank, wr, row, crow, stable, early, done_bank, again, wt);
         n_cmp++; if (bank != exp || done_bank != exp)
                     begin n_err++; $display("FAIL rr_order[%0d]: got bank %0d done %0d want %0d", k, bank, done_bank, exp); end
         n_cmp++; if (exp >= 0 && (row !== row_arr[exp] || crow !== crow_arr[exp] || wr !== wb_flat[exp]))
                     begin n_err++; $display("FAIL rr_fields[%0d]: got %h/%h/%b want %h/%h/%b", k, row, crow, wr, row_arr[exp], crow_arr[exp], wb_flat[exp]); end
         n_cmp++; if (bank == prev || again || early)
                     begin n_err++; $display("FAIL rr_repeat[%0d]: got bank %0d prev %0d again %0d early %0d want distinct, single pulse", k, bank, prev, again, early); end
         prev = bank;
         last = exp;
         ptr_m = (exp + 1) % NB;
      end
      req_flat = '0;
      tick();
   endtask

   task automatic test_backpressure();
      int b, bank, done_bank, wt;
      logic wr, exp_wr; logic [16:0] row, exp_row; logic [4:0] crow, exp_crow;
      bit stable, early, again;
      host_beat = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      n_cmp++; if (busy !== 1'b0 || done_flat !== '0)
                  begin n_err++; $display("FAIL stray_idle: got busy %b done %h want 0/0", busy, done_flat); end
      randomize_fields();
      b = $urandom_range(NB - 1, 0);
      exp_row = row_arr[b]; exp_crow = crow_arr[b]; exp_wr = wb_flat[b];
      req_flat[b] = 1'b1;
      run_transfer(5, 3, 1'b1, bank, wr, row, crow, stable, early, done_bank, again, wt);
      n_cmp++; if (bank != b || row !== exp_row || crow !== exp_crow || wr !== exp_wr)
                  begin n_err++; $display("FAIL bp_cmd: got %0d/%h/%h/%b want %0d/%h/%h/%b", bank, row, crow, wr, b, exp_row, exp_crow, exp_wr); end
      n_cmp++; if (!stable) begin n_err++; $display("FAIL bp_stable: got unstable want stable"); end
      n_cmp++; if (early || done_bank != b || again)
                  begin n_err++; $display("FAIL bp_done: got early %0d bank %0d again %0d want 0/%0d/0", early, done_bank, again, b); end
      ptr_m = (b + 1) % NB;
      req_flat = '0;
      tick();
   endtask

   task automatic test_reset_mid_data();
      int b, k, bank, done_bank, wt;
      logic wr; logic [16:0] row; logic [4:0] crow;
      bit stable, early, again, seen;
      randomize_fields();
      b = $urandom_range(NB - 1, 0);
      req_flat[b] = 1'b1;
      k = 0;
      while (host_cmd_valid !== 1'b1 && k < 50) begin tick(); k++; end
      host_cmd_ready = 1'b1; tick(); host_cmd_ready = 1'b0;
      host_beat = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      host_beat = 1'b0;
      #2 rst = 1'b1;
      tick();
      n_cmp++; if (busy !== 1'b0 || host_cmd_valid !== 1'b0 || done_flat !== '0 ||
                   {host_cmd_wr, host_cmd_row, host_cmd_crow, host_cmd_bank} !== '0)
                  begin n_err++; $display("FAIL rst_mid: got busy %b valid %b done %h bank %0d want all 0", busy, host_cmd_valid, done_flat, host_cmd_bank); end
      seen = (done_flat !== '0);
      tick();
      rst = 1'b0;
      ptr_m = 0;
      run_transfer(1, 1, 1'b0, bank, wr, row, crow, stable, early, done_bank, again, wt);
      n_cmp++; if (seen || early || bank != b || done_bank != b || row !== row_arr[b])
                  begin n_err++; $display("FAIL rst_reserve: got bank %0d done %0d early %0d want %0d/%0d/0", bank, done_bank, early, b, b); end
      ptr_m = (b + 1) % NB;
      req_flat = '0;
      tick();
   endtask

   task automatic test_back_to_back();
      int exp, cnt, bank, done_bank, wt;
      logic wr; logic [16:0] row; logic [4:0] crow;
      bit stable, early, again;
      for (int round = 0; round < 3; round++) begin
         randomize_fields();
         req_flat = 16'($urandom) | 16'(1 << $urandom_range(NB - 1, 0));
         cnt = $countones(req_flat);
         for (int k = 0; k < cnt; k++) begin
            exp = first_req(req_flat, ptr_m, -1);
            run_transfer($urandom_range(2, 0), 2, 1'b0, bank, wr, row, crow, stable, early, done_bank, again, wt);
            n_cmp++; if (bank != exp || done_bank != exp || early)
                        begin n_err++; $display("FAIL b2b_order[%0d.%0d]: got %0d done %0d want %0d", round, k, bank, done_bank, exp); end
            n_cmp++; if (exp >= 0 && (row !== row_arr[exp] || crow !== crow_arr[exp] || wr !== wb_flat[exp]))
                        begin n_err++; $display("FAIL b2b_fields[%0d.%0d]: got %h/%h/%b want %h/%h/%b", round, k, row, crow, wr, row_arr[exp], crow_arr[exp], wb_flat[exp]); end
            if (k > 0) begin
               n_cmp++; if (wt != 1) begin n_err++; $display("FAIL b2b_gap[%0d.%0d]: got %0d want 1", round, k, wt); end
            end
            if (exp >= 0) begin
               req_flat[exp] = 1'b0;
               ptr_m = (exp + 1) % NB;
            end
         end
         req_flat = '0;
         tick();
         tick();
      end
   endtask

   task automatic test_timeout();
      int b, k;
      do_reset();
      randomize_fields();
      b = $urandom_range(NB - 1, 0);
      req_flat[b] = 1'b1;
      k = 0;
      while (host_cmd_valid !== 1'b1 && k < 50) begin tick(); k++; end
      host_cmd_ready = 1'b1; tick(); host_cmd_ready = 1'b0;
`ifdef SYNC_TIMEOUT_EN
      k = 0;
      while (done_flat === '0 && k < 100) begin tick(); k++; end
      n_cmp++; if (k != 16 || onehot_idx(done_flat) != b)
                  begin n_err++; $display("FAIL wd_release: got %0d cycles bank %0d want 16/%0d", k, onehot_idx(done_flat), b); end
      n_cmp++; if (sync_err !== 1'b1) begin n_err++; $display("FAIL wd_err: got %b want 1", sync_err); end
      req_flat = '0;
      for (int i = 0; i < 4; i++) tick();
      n_cmp++; if (sync_err !== 1'b1 || busy !== 1'b0)
                  begin n_err++; $display("FAIL wd_sticky: got err %b busy %b want 1/0", sync_err, busy); end
      do_reset();
      n_cmp++; if (sync_err !== 1'b0) begin n_err++; $display("FAIL wd_clear: got %b want 0", sync_err); end
`else
      k = 0;
      for (int i = 0; i < 40; i++) begin
         if (done_flat !== '0) k++;
         tick();
      end
      n_cmp++; if (busy !== 1'b1 || k != 0 || sync_err !== 1'b0)
                  begin n_err++; $display("FAIL no_wd_wait: got busy %b pulses %0d err %b want 1/0/0", busy, k, sync_err); end
      for (int i = 0; i < BEATS; i++) begin
         host_beat = 1'b1;
         tick();
      end
      host_beat = 1'b0;
      n_cmp++; if (onehot_idx(done_flat) != b)
                  begin n_err++; $display("FAIL no_wd_done: got %h want bank %0d", done_flat, b); end
      req_flat = '0;
      tick();
`endif
   endtask

   initial begin
      rst = 1'b1;
      req_flat = '0; wb_flat = '0; row_arr = '0; crow_arr = '0;
      host_cmd_ready = 1'b0; host_beat = 1'b0;
      test_reset();
      test_single_fill();
      test_round_robin();
      test_backpressure();
      test_reset_mid_data();
      test_back_to_back();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_sync_responder.md
# mem_sync_responder

Backing-store side of the per-bank row-cache sync interface. Each bank's row-cache sync unit raises a sync request when it must fill a cache row from, or write one back to, host memory. This block arbitrates those requests round-robin and issues one command at a time to the host port. It counts the data beats of each row transfer and returns a one-cycle completion pulse to the requesting bank, which then releases its stall. It sits between the bank array and the host memory bridge.

## Interface
Parameters:
- BGWIDTH, 2, bank-group index width; BANKGROUPS = 2**BGWIDTH
- BAWIDTH, 2, bank index width; BANKSPERGROUP = 2**BAWIDTH
- CHWIDTH, 5, cache-row index width
- ADDRWIDTH, 17, DRAM row address width
- BEATS, 8, host data beats per row transfer (≥1)
- SYNC_TIMEOUT, 1024, watchdog limit in cycles (used only with SYNC_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- sync_req  in  [BANKGROUPS-1:0][BANKSPERGROUP-1:0]  level request per bank, held until its sync_done
- sync_wb  in  same shape  request type: 1 = writeback of cache row to host, 0 = fill from host
- RowId  in  [ADDRWIDTH-1:0] per bank  DRAM row to transfer
- cRowId  in  [CHWIDTH-1:0] per bank  cache row slot
- sync_done  out  same shape as sync_req  one-cycle completion pulse to the served bank
- host_cmd_valid  out  1  command valid
- host_cmd_ready  in  1  host accepts command
- host_cmd_wr  out  1  latched sync_wb of the granted bank
- host_cmd_row  out  ADDRWIDTH  latched RowId
- host_cmd_crow  out  CHWIDTH  latched cRowId
- host_cmd_bank  out  BGWIDTH+BAWIDTH  flat bank index {bg,ba}
- host_beat  in  1  one data beat completed
- busy  out  1  state ≠ IDLE
- sync_err  out  1  sticky watchdog error

## Operation
- Flat bank index = bg*BANKSPERGROUP + ba. N = BANKGROUPS*BANKSPERGROUP.
- FSM states: IDLE, CMD, DATA, DONE.
- IDLE: if any unmasked sync_req, the round-robin arbiter picks the first requester at or above rr_ptr, wrapping. Grant index, sync_wb, RowId and cRowId of that bank are registered. Next state is CMD.
- CMD: host_cmd_valid = 1 with the latched fields. On host_cmd_ready, clear beat_cnt and go to DATA.
- DATA: each host_beat increments beat_cnt. A host_beat while beat_cnt == BEATS-1 goes to DONE.
- DONE: sync_done[grant] = 1 for this cycle only. rr_ptr = (grant+1) mod N. Next state is IDLE.
- In the IDLE cycle right after DONE, the just-served bank is masked from arbitration, so a bank whose req is still high is not re-served. The mask lasts one cycle.
- host_beat outside DATA is ignored. Changes to requests or request fields after grant are ignored. Deasserting the granted sync_req mid-service does not abort; the transfer completes and sync_done still pulses.
- beat_cnt width is $clog2(BEATS)+1; it never wraps.

## Timing
- Reset values: state IDLE, rr_ptr 0, mask clear, all outputs 0 (sync_done all 0, host_cmd_* 0, busy 0, sync_err 0).
- Asserting rst mid-transfer aborts immediately to IDLE. No sync_done is issued for the aborted transfer.
- sync_done, host_cmd_valid and busy are decoded from the state register (Moore). host_cmd_* fields are register outputs.
- Minimum latency: req seen in IDLE at cycle 0 → CMD at cycle 1. With ready in cycle 1, the first beat can arrive in cycle 2. sync_done occurs at cycle BEATS+2.
- Back-to-back: a different pending bank is granted in the IDLE cycle after DONE, so there is a 2-cycle gap between consecutive commands.

## Configuration
- SYNC_TIMEOUT_EN defined:
  - A watchdog counts cycles in CMD/DATA without host_cmd_ready or host_beat.
  - When it reaches SYNC_TIMEOUT: sync_err is set (sticky until rst) and the FSM goes to DONE, so the bank is released.
  - The watchdog clears on every progress event.
- SYNC_TIMEOUT_EN undefined: no counter, sync_err tied 0, and the FSM waits indefinitely.

## Structure
- Package mem_sync_pkg holds:
  - the FSM state enum (sync_state_t)
  - the request type enum (SYNC_FILL/SYNC_WB)
  - a function for the flat bank index
- Sub-module mem_sync_rr_arb: N-way round-robin arbiter. Inputs are request vector, mask and pointer; outputs are a one-hot grant and an encoded index.

## Test plan
- Single fill: bank {1,2} req, wb=0, RowId 0x1ABCD, cRowId 7; ready in first CMD cycle; 8 consecutive beats → one host command with bank 6, row 0x1ABCD, crow 7, wr 0; sync_done[1][2] pulses exactly at cycle 10.
- Round-robin: banks 0, 5 and 15 request together and hold → served in order 0, 5, 15; then with rr_ptr 0 and all three still requesting → 0 again; no bank served twice consecutively.
- Backpressure and gaps: host_cmd_ready low for 5 cycles; beats with random idle cycles; stray beats during IDLE → fields stable while valid is high; exactly BEATS counted beats; stray beats ignored.
- Reset mid-DATA after 3 beats → all outputs 0 next edge, no sync_done; the re-raised request is served from scratch.
- With SYNC_TIMEOUT_EN and SYNC_TIMEOUT=16: no beats after the command is accepted → sync_err rises and sync_done pulses 16 cycles after the last progress; sync_err stays high until rst.
